serial_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes operands LSB-first, DIGIT bits per clock, through a registered carry chain. It is the sequential, width-generic successor to the single-bit full adder cell in the ALU: it trades latency for area in the low-cost ALU datapath, and it adds subtract, signed-overflow and a start/done handshake.

---
 rtl/serial_addsub.sv | 131 +++++++++++++
 tb/tb_serial_addsub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// LSB-first multi-cycle adder/subtractor: DIGIT bits per clock through a registered
// carry. It exposes a start/busy/done handshake, and its results are registered on completion.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nx_s;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [DIGIT:0]   ext_s;
    logic             cmsb_s;
    logic             load_s;
    logic             last_s;

    function automatic logic [DIGIT:0] slice_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             c);
        slice_add = {1'b0, x} + {1'b0, y} + (DIGIT+1)'(c);
    endfunction

    // Next-state decode and operand-load / completion strobes
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    state_nx_s = DONE;
                    last_s     = 1'b1;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx_s = RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Current slice sum; the carry into the operand MSB is recovered from the sum bit
    always_comb begin
        ext_s    = slice_add(opa_r[DIGIT-1:0], opb_r[DIGIT-1:0], carry_r);
        cmsb_s   = ext_s[DIGIT-1] ^ opa_r[DIGIT-1] ^ opb_r[DIGIT-1];
        acc_nx_s = acc_r >> DIGIT;
        acc_nx_s[WIDTH-1 -: DIGIT] = ext_s[DIGIT-1:0];
    end

    // State, datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum     <= {WIDTH{1'b0}};
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy    <= (state_nx_s == RUN);
            done    <= (state_nx_s == DONE);
            if (load_s) begin
                opa_r   <= a;
                opb_r   <= b ^ {WIDTH{sub}};
                carry_r <= ci ^ sub;
                acc_r   <= {WIDTH{1'b0}};
                cnt_r   <= {CW{1'b0}};
            end else if (state_r == RUN) begin
                opa_r   <= opa_r >> DIGIT;
                opb_r   <= opb_r >> DIGIT;
                carry_r <= ext_s[DIGIT];
                acc_r   <= acc_nx_s;
                cnt_r   <= last_s ? {CW{1'b0}} : cnt_r + CW'(1'b1);
            end
            if (last_s) begin
                sum <= acc_nx_s;
                co  <= ext_s[DIGIT];
                ovf <= cmsb_s ^ ext_s[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8-bit instances (DIGIT 1 and 4) for handshake,
// reset and back-to-back behaviour; five 16-bit instances for a DIGIT sweep.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, sub8, ci8;
    logic [7:0] a8, b8;
    logic       busy81, done81, co81, ovf81;
    logic [7:0] sum81;
    logic       busy84, done84, co84, ovf84;
    logic [7:0] sum84;

    logic        start16, sub16, ci16;
    logic [15:0] a16, b16;
    logic        busy16 [5];
    logic        done16 [5];
    logic        co16   [5];
    logic        ovf16  [5];
    logic [15:0] sum16  [5];

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d81 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy81), .done(done81), .sum(sum81), .co(co81), .ovf(ovf81));

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d84 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy84), .done(done84), .sum(sum84), .co(co84), .ovf(ovf84));

    generate
        for (genvar g = 0; g < 5; g++) begin : g_d16
            serial_addsub #(.WIDTH(16), .DIGIT(1 << g)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
                .ci(ci16), .busy(busy16[g]), .done(done16[g]), .sum(sum16[g]),
                .co(co16[g]), .ovf(ovf16[g]));
        end
    endgenerate

    // Launch one 8-bit operation and wait (bounded) for its done; lat = -1 on timeout
    task automatic do_op8(input bit d4, input logic [7:0] aa, input logic [7:0] bb,
                          input logic s, input logic c, output int lat, output int bcnt,
                          output logic [7:0] sm, output logic co_o, output logic ovf_o);
        repeat (10) @(negedge clk);
        start8 = 1'b1; a8 = aa; b8 = bb; sub8 = s; ci8 = c;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1; sm = 8'h00; co_o = 1'b0; ovf_o = 1'b0;
        bcnt = (d4 ? busy84 : busy81) ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (d4 ? done84 : done81) begin
                lat = k; sm = d4 ? sum84 : sum81;
                co_o = d4 ? co84 : co81; ovf_o = d4 ? ovf84 : ovf81;
                break;
            end
            if (d4 ? busy84 : busy81) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (busy81 !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy81); end
        n_checks++; if (done81 !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done81); end
        n_checks++; if (sum81 !== 8'h00) begin n_fail++; $display("FAIL reset sum: got %h expected 00", sum81); end
        n_checks++; if ({co81, ovf81} !== 2'b00) begin n_fail++; $display("FAIL reset co/ovf: got %b%b expected 00", co81, ovf81); end
        n_checks++; if (sum16[0] !== 16'h0000) begin n_fail++; $display("FAIL reset sum16: got %h expected 0000", sum16[0]); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        int lat, bcnt; logic [7:0] sm; logic c, v;
        do_op8(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, lat, bcnt, sm, c, v);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL add latency: got %0d expected 8", lat); end
        n_checks++; if (bcnt !== 8) begin n_fail++; $display("FAIL add busy cycles: got %0d expected 8", bcnt); end
        n_checks++; if (sm !== 8'h80) begin n_fail++; $display("FAIL add sum: got %h expected 80", sm); end
        n_checks++; if ({c, v} !== 2'b01) begin n_fail++; $display("FAIL add co/ovf: got %b%b expected 01", c, v); end
    endtask

    task automatic test_sub();
        int lat, bcnt; logic [7:0] sm; logic c, v;
        do_op8(1'b0, 8'h05, 8'h07, 1'b1, 1'b0, lat, bcnt, sm, c, v);
        n_checks++; if (sm !== 8'hFE) begin n_fail++; $display("FAIL sub sum: got %h expected fe", sm); end
        n_checks++; if ({c, v} !== 2'b00) begin n_fail++; $display("FAIL sub co/ovf: got %b%b expected 00", c, v); end
        do_op8(1'b0, 8'h05, 8'h07, 1'b1, 1'b1, lat, bcnt, sm, c, v);
        n_checks++; if (sm !== 8'hFD) begin n_fail++; $display("FAIL sub borrow-in sum: got %h expected fd", sm); end
        n_checks++; if ({c, v} !== 2'b00) begin n_fail++; $display("FAIL sub borrow-in co/ovf: got %b%b expected 00", c, v); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL sub latency: got %0d expected 8", lat); end
    endtask

    task automatic test_digit4();
        int lat, bcnt; logic [7:0] sm; logic c, v;
        do_op8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, lat, bcnt, sm, c, v);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL d4 latency: got %0d expected 2", lat); end
        n_checks++; if (bcnt !== 2) begin n_fail++; $display("FAIL d4 busy cycles: got %0d expected 2", bcnt); end
        n_checks++; if (sm !== 8'h01) begin n_fail++; $display("FAIL d4 sum: got %h expected 01", sm); end
        n_checks++; if ({c, v} !== 2'b10) begin n_fail++; $display("FAIL d4 co/ovf: got %b%b expected 10", c, v); end
    endtask

    task automatic test_back_to_back();
        int lat;
        repeat (10) @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; ci8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; ci8 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start8 = (k == 3);
            if (done81) begin lat = k; break; end
        end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b first latency: got %0d expected 8", lat); end
        n_checks++; if (sum81 !== 8'h46) begin n_fail++; $display("FAIL b2b first sum: got %h expected 46", sum81); end
        n_checks++; if ({co81, ovf81} !== 2'b00) begin n_fail++; $display("FAIL b2b first co/ovf: got %b%b expected 00", co81, ovf81); end
        start8 = 1'b1; a8 = 8'hC0; b8 = 8'h50; sub8 = 1'b0; ci8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++; if ({busy81, done81} !== 2'b10) begin n_fail++; $display("FAIL b2b restart busy/done: got %b%b expected 10", busy81, done81); end
        n_checks++; if (sum81 !== 8'h46) begin n_fail++; $display("FAIL b2b sum hold: got %h expected 46", sum81); end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done81) begin lat = k; break; end
        end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b second latency: got %0d expected 8", lat); end
        n_checks++; if (sum81 !== 8'h10) begin n_fail++; $display("FAIL b2b second sum: got %h expected 10", sum81); end
        n_checks++; if ({co81, ovf81} !== 2'b10) begin n_fail++; $display("FAIL b2b second co/ovf: got %b%b expected 10", co81, ovf81); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt, ndone; logic [7:0] sm; logic c, v;
        repeat (10) @(negedge clk);
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; ci8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({busy81, done81} !== 2'b00) begin n_fail++; $display("FAIL abort busy/done: got %b%b expected 00", busy81, done81); end
        n_checks++; if (sum81 !== 8'h00) begin n_fail++; $display("FAIL abort sum: got %h expected 00", sum81); end
        n_checks++; if ({co81, ovf81} !== 2'b00) begin n_fail++; $display("FAIL abort co/ovf: got %b%b expected 00", co81, ovf81); end
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done81) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort stray done: got %0d pulses expected 0", ndone); end
        do_op8(1'b0, 8'h11, 8'h22, 1'b0, 1'b0, lat, bcnt, sm, c, v);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL post-abort latency: got %0d expected 8", lat); end
        n_checks++; if (sm !== 8'h33) begin n_fail++; $display("FAIL post-abort sum: got %h expected 33", sm); end
    endtask

    task automatic test_digit_sweep();
        logic [15:0] ta [10] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234, 16'h0000,
                                 16'h8000, 16'h1234, 16'h7FFF, 16'hABCD, 16'hFFFF};
        logic [15:0] tb [10] = '{16'h0001, 16'h0001, 16'h8000, 16'h4321, 16'h0001,
                                 16'h0001, 16'h1234, 16'hFFFF, 16'h1111, 16'hFFFF};
        logic        ts [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        tc [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] es [10] = '{16'h8000, 16'h0000, 16'h0000, 16'h5556, 16'hFFFF,
                                 16'h7FFF, 16'hFFFF, 16'h8000, 16'hBCDE, 16'hFFFF};
        logic        ec [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ev [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int          lat [5];
        logic [15:0] gs  [5];
        logic        gc  [5];
        logic        gv  [5];
        for (int i = 0; i < 10; i++) begin
            repeat (2) @(negedge clk);
            start16 = 1'b1; a16 = ta[i]; b16 = tb[i]; sub16 = ts[i]; ci16 = tc[i];
            @(posedge clk); #1;
            start16 = 1'b0; a16 = ~ta[i]; b16 = ~tb[i]; ci16 = ~tc[i];
            for (int g = 0; g < 5; g++) begin lat[g] = -1; gs[g] = 16'h0000; gc[g] = 1'b0; gv[g] = 1'b0; end
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 5; g++) begin
                    if (done16[g] && lat[g] < 0) begin
                        lat[g] = k; gs[g] = sum16[g]; gc[g] = co16[g]; gv[g] = ovf16[g];
                    end
                end
            end
            for (int g = 0; g < 5; g++) begin
                n_checks++; if (lat[g] !== (16 >> g)) begin n_fail++; $display("FAIL sweep[%0d] digit %0d latency: got %0d expected %0d", i, 1 << g, lat[g], 16 >> g); end
                n_checks++; if (gs[g] !== es[i]) begin n_fail++; $display("FAIL sweep[%0d] digit %0d sum: got %h expected %h", i, 1 << g, gs[g], es[i]); end
                n_checks++; if (gc[g] !== ec[i]) begin n_fail++; $display("FAIL sweep[%0d] digit %0d co: got %b expected %b", i, 1 << g, gc[g], ec[i]); end
                n_checks++; if (gv[g] !== ev[i]) begin n_fail++; $display("FAIL sweep[%0d] digit %0d ovf: got %b expected %b", i, 1 << g, gv[g], ev[i]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; sub16 = 1'b0; ci16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        test_reset();
        test_add_overflow();
        test_sub();
        test_digit4();
        test_back_to_back();
        test_reset_mid_run();
        test_digit_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
